// File: rtl/debug_output_mux.sv
`default_nettype none
// ============================================================================
// Module   : debug_output_mux
// Summary  : NUM_GPIO debug pins, each selecting one internal signal (period
//            marker, thermo, STM/MOD segment, PWM channel, static level,
//            UPDATE toggle, stretched UPDATE pulse). Selections are captured
//            into a pending set on CFG_UPDATE and become active on UPDATE.
//            All sources reach GPIO_OUT through two register stages.
// Options  : AUTD3_DEBUG_STRETCH_EN - enables the STRETCH source (type 8);
//            when undefined, type 8 is reserved and outputs 0.
// Revision : 1.0 - initial release
// ============================================================================
module debug_output_mux #(
  parameter int DEPTH     = 249,
  parameter int NUM_GPIO  = 4,
  parameter int STRETCH_W = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [8:0]              TIME_CNT,
  input  logic                    UPDATE,
  input  logic [DEPTH-1:0]        PWM_IN,
  input  logic                    THERMO,
  input  logic                    STM_SEGMENT,
  input  logic                    MOD_SEGMENT,
  input  logic [4*NUM_GPIO-1:0]   SEL_TYPE,
  input  logic [16*NUM_GPIO-1:0]  SEL_VALUE,
  input  logic                    CFG_UPDATE,
  output logic [NUM_GPIO-1:0]     GPIO_OUT
);

  // PWM channels are grouped by 16; the last group is zero padded.
  localparam int          c_GROUPS  = (DEPTH + 15) / 16;
  localparam int          c_GW      = (c_GROUPS > 1) ? $clog2(c_GROUPS) : 1;
  localparam int          c_GSLOTS  = 1 << c_GW;
  localparam logic [16:0] c_DEPTH_V = 17'(DEPTH);

  localparam logic [3:0] c_TYPE_NONE    = 4'd0;
  localparam logic [3:0] c_TYPE_PERIOD  = 4'd1;
  localparam logic [3:0] c_TYPE_THERMO  = 4'd2;
  localparam logic [3:0] c_TYPE_STM     = 4'd3;
  localparam logic [3:0] c_TYPE_MOD     = 4'd4;
  localparam logic [3:0] c_TYPE_PWM     = 4'd5;
  localparam logic [3:0] c_TYPE_STATIC  = 4'd6;
  localparam logic [3:0] c_TYPE_TOGGLE  = 4'd7;
`ifdef AUTD3_DEBUG_STRETCH_EN
  localparam logic [3:0] c_TYPE_STRETCH = 4'd8;
`endif

  // Elaboration-time parameter sanity checks
  if (STRETCH_W < 1 || STRETCH_W > 16) begin : g_bad_stretch_w
    $error("debug_output_mux: STRETCH_W must be in 1..16");
  end
  if (DEPTH < 1 || DEPTH > 65536) begin : g_bad_depth
    $error("debug_output_mux: DEPTH must be in 1..65536");
  end

  // --------------------------------------------------------------------------
  // Shared sources
  // --------------------------------------------------------------------------
  logic                     w_period;
  logic [c_GROUPS*16-1:0]   w_pwm_pad;
  logic [15:0]              w_pwm_grp [c_GROUPS];

  assign w_period = (TIME_CNT < 9'd256);

  // Zero-extend the PWM bus to a whole number of 16-channel groups
  always_comb begin
    w_pwm_pad              = '0;
    w_pwm_pad[DEPTH-1:0]   = PWM_IN;
  end

  for (genvar g = 0; g < c_GROUPS; g++) begin : g_pwm_grp
    assign w_pwm_grp[g] = w_pwm_pad[g*16 +: 16];
  end

  // --------------------------------------------------------------------------
  // Per-pin selection
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
    logic [3:0]           r_pend_type;
    logic [15:0]          r_pend_val;
    logic [3:0]           r_act_type;
    logic [15:0]          r_act_val;
    logic                 w_type_change;
    logic                 r_tog;
    logic                 w_tog_nxt;
    logic                 w_in_range;
    logic                 w_s1;
    logic                 r_s1;
    logic                 r_is_pwm_d;
    logic [c_GW-1:0]      r_gidx_d;
    logic [c_GROUPS-1:0]  w_grp_sel;
    logic [c_GROUPS-1:0]  r_grp;
    logic [c_GSLOTS-1:0]  w_grp_all;
    logic                 w_grp_bit;
    logic                 r_out;

    // Pending set follows CFG_UPDATE; active set takes the old pending on UPDATE
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_pend_type <= 4'd0;
        r_pend_val  <= 16'd0;
        r_act_type  <= 4'd0;
        r_act_val   <= 16'd0;
      end else begin
        if (CFG_UPDATE) begin
          r_pend_type <= SEL_TYPE[4*i +: 4];
          r_pend_val  <= SEL_VALUE[16*i +: 16];
        end
        if (UPDATE) begin
          r_act_type <= r_pend_type;
          r_act_val  <= r_pend_val;
        end
      end
    end

    // The toggle restarts from 0 whenever this UPDATE changes the active type.
    // Its next value feeds stage 1 directly so the flip lands 2 cycles after UPDATE.
    assign w_type_change = (r_pend_type != r_act_type);
    assign w_tog_nxt     = UPDATE ? (w_type_change ? 1'b0 : ~r_tog) : r_tog;

    // Toggle state register
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_tog <= 1'b0;
      end else begin
        r_tog <= w_tog_nxt;
      end
    end

`ifdef AUTD3_DEBUG_STRETCH_EN
    logic [STRETCH_W-1:0] r_cnt;
    logic [STRETCH_W-1:0] w_cnt_nxt;
    logic [STRETCH_W-1:0] w_load;
    logic                 w_stretch;

    // Reload length is the value of the set in effect after this UPDATE, min 1
    always_comb begin
      w_load = r_pend_val[STRETCH_W-1:0];
      if (w_load == '0) begin
        w_load = STRETCH_W'(1);
      end
    end

    // UPDATE reloads (retrigger, no accumulation); otherwise count down to 0
    always_comb begin
      w_cnt_nxt = r_cnt;
      if (UPDATE) begin
        w_cnt_nxt = w_load;
      end else if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - STRETCH_W'(1);
      end
    end

    assign w_stretch = (w_cnt_nxt != '0);

    // Pulse-stretch counter
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_nxt;
      end
    end
`endif

    assign w_in_range = ({1'b0, r_act_val} < c_DEPTH_V);

    // PWM stage 1: pick the channel inside every group
    for (genvar g = 0; g < c_GROUPS; g++) begin : g_grp
      assign w_grp_sel[g] = w_pwm_grp[g][r_act_val[3:0]];
    end

    // Non-PWM sources; for PWM this carries the index range check
    always_comb begin
      w_s1 = 1'b0;
      case (r_act_type)
        c_TYPE_NONE:    w_s1 = 1'b0;
        c_TYPE_PERIOD:  w_s1 = w_period;
        c_TYPE_THERMO:  w_s1 = THERMO;
        c_TYPE_STM:     w_s1 = STM_SEGMENT;
        c_TYPE_MOD:     w_s1 = MOD_SEGMENT;
        c_TYPE_PWM:     w_s1 = w_in_range;
        c_TYPE_STATIC:  w_s1 = r_act_val[0];
        c_TYPE_TOGGLE:  w_s1 = w_tog_nxt;
`ifdef AUTD3_DEBUG_STRETCH_EN
        c_TYPE_STRETCH: w_s1 = w_stretch;
`endif
        default:        w_s1 = 1'b0;
      endcase
    end

    // Stage 1 registers, with the group index delayed to line up with them
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_grp      <= '0;
        r_s1       <= 1'b0;
        r_is_pwm_d <= 1'b0;
        r_gidx_d   <= '0;
      end else begin
        r_grp      <= w_grp_sel;
        r_s1       <= w_s1;
        r_is_pwm_d <= (r_act_type == c_TYPE_PWM);
        r_gidx_d   <= r_act_val[4 +: c_GW];
      end
    end

    // PWM stage 2: pick the group (unused slots read as 0)
    always_comb begin
      w_grp_all                 = '0;
      w_grp_all[c_GROUPS-1:0]   = r_grp;
      w_grp_bit                 = w_grp_all[r_gidx_d];
    end

    // Output register
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_out <= 1'b0;
      end else begin
        r_out <= r_is_pwm_d ? (r_s1 & w_grp_bit) : r_s1;
      end
    end

    assign GPIO_OUT[i] = r_out;
  end

endmodule
`default_nettype wire

// File: tb/tb_debug_output_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_output_mux
// Summary  : Self-checking bench for debug_output_mux. A behavioural model
//            tracks the pending/active sets, the toggle parity and the time
//            since the last UPDATE; its expected pin values are delayed by
//            two cycles and compared with GPIO_OUT every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_output_mux;

  localparam int DEPTH     = 249;
  localparam int NUM_GPIO  = 4;
  localparam int STRETCH_W = 8;
`ifdef AUTD3_DEBUG_STRETCH_EN
  localparam bit STRETCH_ON = 1'b1;
`else
  localparam bit STRETCH_ON = 1'b0;
`endif

  logic                   CLK = 1'b0;
  logic                   RST;
  logic [8:0]             TIME_CNT;
  logic                   UPDATE;
  logic [DEPTH-1:0]       PWM_IN;
  logic                   THERMO;
  logic                   STM_SEGMENT;
  logic                   MOD_SEGMENT;
  logic [4*NUM_GPIO-1:0]  SEL_TYPE;
  logic [16*NUM_GPIO-1:0] SEL_VALUE;
  logic                   CFG_UPDATE;
  logic [NUM_GPIO-1:0]    GPIO_OUT;

  always #5 CLK = ~CLK;

  debug_output_mux #(
    .DEPTH     (DEPTH),
    .NUM_GPIO  (NUM_GPIO),
    .STRETCH_W (STRETCH_W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .TIME_CNT    (TIME_CNT),
    .UPDATE      (UPDATE),
    .PWM_IN      (PWM_IN),
    .THERMO      (THERMO),
    .STM_SEGMENT (STM_SEGMENT),
    .MOD_SEGMENT (MOD_SEGMENT),
    .SEL_TYPE    (SEL_TYPE),
    .SEL_VALUE   (SEL_VALUE),
    .CFG_UPDATE  (CFG_UPDATE),
    .GPIO_OUT    (GPIO_OUT)
  );

  // Reference model state
  logic [3:0]  m_pend_t [NUM_GPIO];
  logic [15:0] m_pend_v [NUM_GPIO];
  logic [3:0]  m_act_t  [NUM_GPIO];
  logic [15:0] m_act_v  [NUM_GPIO];
  bit          m_tog    [NUM_GPIO];
  int          m_st_last[NUM_GPIO];
  int          m_st_len [NUM_GPIO];
  bit          m_d1     [NUM_GPIO];
  bit          m_d2     [NUM_GPIO];

  int cyc;
  int n_cmp;
  int n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NUM_GPIO; p++) begin
      m_pend_t[p]  = 4'd0;
      m_pend_v[p]  = 16'd0;
      m_act_t[p]   = 4'd0;
      m_act_v[p]   = 16'd0;
      m_tog[p]     = 1'b0;
      m_st_last[p] = 0;
      m_st_len[p]  = 0;
      m_d1[p]      = 1'b0;
      m_d2[p]      = 1'b0;
    end
  endtask

  task automatic set_sel(input int p, input logic [3:0] t, input logic [15:0] v);
    SEL_TYPE[4*p +: 4]   = t;
    SEL_VALUE[16*p +: 16] = v;
  endtask

  task automatic drive_rand();
    for (int b = 0; b < DEPTH; b++) PWM_IN[b] = 1'($urandom_range(0, 1));
    TIME_CNT    = 9'($urandom_range(0, 511));
    THERMO      = 1'($urandom_range(0, 1));
    STM_SEGMENT = 1'($urandom_range(0, 1));
    MOD_SEGMENT = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [15:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom_range(0, 15));
      1:       return 16'($urandom_range(240, 260));
      2:       return 16'($urandom_range(0, 12));
      default: return 16'($urandom);
    endcase
  endfunction

  // One cycle: check GPIO_OUT against the model, then advance the model
  task automatic tick();
    @(negedge CLK);
    for (int p = 0; p < NUM_GPIO; p++)
      chk($sformatf("gpio%0d_cyc%0d", p, cyc), 32'(GPIO_OUT[p]), 32'(m_d2[p]));
    if (RST) begin
      model_reset();
    end else begin
      for (int p = 0; p < NUM_GPIO; p++) begin
        logic [3:0]  ty;
        logic [15:0] v;
        int          idx;
        bit          s;
        ty  = m_act_t[p];
        v   = m_act_v[p];
        idx = int'(v);
        s   = 1'b0;
        if (UPDATE) begin
          m_tog[p]     = (m_pend_t[p] != m_act_t[p]) ? 1'b0 : ~m_tog[p];
          m_st_last[p] = cyc;
          m_st_len[p]  = (m_pend_v[p][7:0] == 8'd0) ? 1 : int'(m_pend_v[p][7:0]);
        end
        case (ty)
          4'd1:    s = (TIME_CNT < 9'd256);
          4'd2:    s = THERMO;
          4'd3:    s = STM_SEGMENT;
          4'd4:    s = MOD_SEGMENT;
          4'd5:    s = (idx < DEPTH) ? PWM_IN[idx] : 1'b0;
          4'd6:    s = v[0];
          4'd7:    s = m_tog[p];
          4'd8:    s = STRETCH_ON && ((cyc - m_st_last[p]) < m_st_len[p]);
          default: s = 1'b0;
        endcase
        if (UPDATE) begin
          m_act_t[p] = m_pend_t[p];
          m_act_v[p] = m_pend_v[p];
        end
        if (CFG_UPDATE) begin
          m_pend_t[p] = SEL_TYPE[4*p +: 4];
          m_pend_v[p] = SEL_VALUE[16*p +: 16];
        end
        m_d2[p] = m_d1[p];
        m_d1[p] = s;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock
  task automatic async_reset();
    #2;
    RST = 1'b1;
    #1;
    chk("rst_async", 32'(GPIO_OUT), 32'd0);
    model_reset();
  endtask

  // Apply a configuration and let it settle
  task automatic apply_cfg(input int settle);
    for (int k = 0; k < settle; k++) begin
      drive_rand();
      CFG_UPDATE = (k == 0);
      UPDATE     = (k == 2);
      tick();
    end
  endtask

  // Count cycles GPIO_OUT[0] is high over a window with UPDATE at 0 and u2
  task automatic run_window(input int len, input int u2, output int cnt);
    cnt = 0;
    for (int k = 0; k < len; k++) begin
      drive_rand();
      CFG_UPDATE = 1'b0;
      UPDATE     = (k == 0) || (k == u2);
      if (GPIO_OUT[0]) cnt++;
      tick();
    end
  endtask

  initial begin
    int cnt;
    RST = 1'b1; UPDATE = 1'b0; CFG_UPDATE = 1'b0; TIME_CNT = 9'd0;
    THERMO = 1'b0; STM_SEGMENT = 1'b0; MOD_SEGMENT = 1'b0;
    PWM_IN = '0; SEL_TYPE = '0; SEL_VALUE = '0;
    cyc = 0; n_cmp = 0; n_bad = 0;
    model_reset();
    @(posedge CLK); #1;

    // Reset state
    for (int k = 0; k < 3; k++) begin drive_rand(); tick(); end
    chk("reset_gpio", 32'(GPIO_OUT), 32'd0);
    RST = 1'b0;

    // Shadowing: CFG at 10, UPDATE at 40, pin 0 static 1 from 43
    set_sel(0, 4'd6, 16'd1);
    for (int k = 0; k < 46; k++) begin
      drive_rand();
      CFG_UPDATE = (k == 10);
      UPDATE     = (k == 40);
      if (k == 42) chk("shadow_c42", 32'(GPIO_OUT[0]), 32'd0);
      if (k == 43) chk("shadow_c43", 32'(GPIO_OUT[0]), 32'd1);
      tick();
    end

    // PWM select: channel 200 rising at 8 appears at 10
    set_sel(1, 4'd5, 16'd200);
    for (int k = 0; k < 12; k++) begin
      drive_rand();
      PWM_IN     = '0;
      if (k >= 8) PWM_IN[200] = 1'b1;
      CFG_UPDATE = (k == 0);
      UPDATE     = (k == 2);
      if (k == 9)  chk("pwm200_n1", 32'(GPIO_OUT[1]), 32'd0);
      if (k == 10) chk("pwm200_n2", 32'(GPIO_OUT[1]), 32'd1);
      tick();
    end

    // PWM index boundaries with every channel high
    for (int t = 0; t < 3; t++) begin
      logic [15:0] v;
      v = (t == 0) ? 16'd248 : ((t == 1) ? 16'd249 : 16'd256);
      set_sel(1, 4'd5, v);
      for (int k = 0; k < 8; k++) begin
        drive_rand();
        PWM_IN     = '1;
        CFG_UPDATE = (k == 0);
        UPDATE     = (k == 2);
        if (k == 6) chk($sformatf("pwm_idx%0d", v), 32'(GPIO_OUT[1]), (v < 16'd249) ? 32'd1 : 32'd0);
        tick();
      end
    end

    // Simultaneous strobes: pin 2 thermo only after the UPDATE at 532
    set_sel(2, 4'd2, 16'd0);
    for (int k = 0; k < 538; k++) begin
      drive_rand();
      THERMO     = 1'b1;
      CFG_UPDATE = (k == 20);
      UPDATE     = (k == 20) || (k == 532);
      if (k == 300) chk("simul_c300", 32'(GPIO_OUT[2]), 32'd0);
      if (k == 534) chk("simul_c534", 32'(GPIO_OUT[2]), 32'd0);
      if (k == 535) chk("simul_c535", 32'(GPIO_OUT[2]), 32'd1);
      tick();
    end

    // Toggle: pin 3, UPDATEs at 10/20/30/40 give 1,0,1,0 two cycles later
    set_sel(3, 4'd7, 16'd0);
    for (int k = 0; k < 45; k++) begin
      drive_rand();
      CFG_UPDATE = (k == 0);
      UPDATE     = (k == 2) || (k == 10) || (k == 20) || (k == 30) || (k == 40);
      if (k >= 11 && (k % 10) == 1)
        chk($sformatf("tog_pre%0d", (k - 11) / 10), 32'(GPIO_OUT[3]), (((k - 11) / 10) % 2 == 0) ? 32'd0 : 32'd1);
      if (k >= 12 && (k % 10) == 2)
        chk($sformatf("tog_post%0d", (k - 12) / 10), 32'(GPIO_OUT[3]), (((k - 12) / 10) % 2 == 0) ? 32'd1 : 32'd0);
      tick();
    end

    // Stretch on pin 0
    set_sel(0, 4'd8, 16'd5);
    apply_cfg(20);
    run_window(20, -1, cnt);
    chk("stretch_len5", 32'(cnt), STRETCH_ON ? 32'd5 : 32'd0);
    run_window(20, 3, cnt);
    chk("stretch_retrig", 32'(cnt), STRETCH_ON ? 32'd8 : 32'd0);
    set_sel(0, 4'd8, 16'd0);
    apply_cfg(12);
    run_window(10, -1, cnt);
    chk("stretch_len0", 32'(cnt), STRETCH_ON ? 32'd1 : 32'd0);
    set_sel(0, 4'd8, 16'd255);
    apply_cfg(270);
    run_window(270, -1, cnt);
    chk("stretch_len255", 32'(cnt), STRETCH_ON ? 32'd255 : 32'd0);

    // Mid-stream reset with pin 0 on PWM channel 10 held high
    set_sel(0, 4'd5, 16'd10);
    for (int k = 0; k < 10; k++) begin
      drive_rand();
      PWM_IN[10] = 1'b1;
      CFG_UPDATE = (k == 0);
      UPDATE     = (k == 2);
      tick();
    end
    drive_rand();
    PWM_IN[10] = 1'b1;
    chk("pre_rst", 32'(GPIO_OUT[0]), 32'd1);
    async_reset();
    tick();
    drive_rand();
    tick();
    RST = 1'b0;
    for (int k = 0; k < 30; k++) begin
      drive_rand();
      CFG_UPDATE = 1'b0;
      UPDATE     = (k % 10 == 0);
      chk($sformatf("post_rst_c%0d", k), 32'(GPIO_OUT), 32'd0);
      tick();
    end

    // Randomised traffic with one reset in the middle
    for (int k = 0; k < 3000; k++) begin
      if (k == 1502) RST = 1'b0;
      drive_rand();
      CFG_UPDATE = ($urandom_range(0, 15) == 0);
      if (CFG_UPDATE)
        for (int p = 0; p < NUM_GPIO; p++) set_sel(p, 4'($urandom_range(0, 15)), rand_val());
      UPDATE = ($urandom_range(0, 8) == 0);
      if (k == 1500) async_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debug_output_mux.md
# debug_output_mux

Parametrised debug GPIO generator replacing the fixed two-pin debug logic at the top level. It drives `NUM_GPIO` debug pins. Each pin independently selects one internal signal: PWM period marker, thermo, STM/MOD segment, any PWM channel, a static level, an UPDATE toggle, or a stretched UPDATE pulse. Selections are shadowed and switch only on the PWM-period `UPDATE` strobe, so a scope never sees a mid-period glitch. The block sits beside `pwm` and takes its settings from `controller`.

## Interface
Parameters:
- `DEPTH`, 249, number of PWM channels on `PWM_IN`
- `NUM_GPIO`, 4, number of debug output pins
- `STRETCH_W`, 8, width of the pulse-stretch counter and of the used `SEL_VALUE` LSBs for stretch

Ports:
- `CLK`  in  1  system clock; the only clock
- `RST`  in  1  asynchronous, active-high reset
- `TIME_CNT`  in  9  PWM time counter, 0..511
- `UPDATE`  in  1  one-cycle strobe at each PWM period start
- `PWM_IN`  in  1 x `DEPTH`  PWM outputs
- `THERMO`  in  1  thermal sensor level
- `STM_SEGMENT`  in  1  current STM segment
- `MOD_SEGMENT`  in  1  current modulation segment
- `SEL_TYPE`  in  4 x `NUM_GPIO`  per-pin source type
- `SEL_VALUE`  in  16 x `NUM_GPIO`  per-pin source argument
- `CFG_UPDATE`  in  1  one-cycle strobe; captures `SEL_TYPE`/`SEL_VALUE` into the pending set
- `GPIO_OUT`  out  1 x `NUM_GPIO`  debug pins, registered

## Operation
- Config path: `CFG_UPDATE`=1 copies all `SEL_*` into pending registers. On the next `UPDATE`=1, pending is copied to active.
- If `CFG_UPDATE` and `UPDATE` are high in the same cycle, pending captures the new value. Active takes the old pending value. The new set applies at the following `UPDATE`.
- Multiple `CFG_UPDATE` strobes before an `UPDATE`: the last one wins.
- Per-pin source, selected by the active type:
  - 0 NONE: 0
  - 1 PERIOD: `TIME_CNT < 256`
  - 2 THERMO
  - 3 STM_SEGMENT
  - 4 MOD_SEGMENT
  - 5 PWM: `PWM_IN[SEL_VALUE]`; an index ≥ `DEPTH` gives 0
  - 6 STATIC: `SEL_VALUE[0]`
  - 7 TOGGLE: flips on every `UPDATE`; clears to 0 when the pin's active type changes
  - 8 STRETCH: see Configuration
  - 9..15 reserved: output 0
- PWM selection is a two-stage mux. Stage 1 selects within groups of 16; stage 2 selects the group.
- Every other source is delayed by matching registers, so all types have equal latency.

## Timing
- Reset values:
  - all `GPIO_OUT`: 0
  - active and pending types: 0, values: 0
  - toggle state: 0
  - stretch counters: 0
- Latency: a source change at cycle N appears on `GPIO_OUT` at cycle N+2, for all types.
- Config switch: with `UPDATE` at cycle N, the active set changes at N+1. Output reflects the new source from N+3.
- Pins are fully independent; no cross-pin ordering.
- Reset asserted mid-operation forces reset values immediately (asynchronously). The first `UPDATE` after release applies nothing unless `CFG_UPDATE` was seen after release.

## Configuration
- Macro `AUTD3_DEBUG_STRETCH_EN`.
- Defined, type 8 is STRETCH:
  - each `UPDATE` loads the pin counter with `max(SEL_VALUE[STRETCH_W-1:0], 1)`
  - the pin source is 1 while the counter is nonzero; the counter decrements every cycle
  - `UPDATE` while counting reloads the counter (retrigger, no accumulation)
  - `SEL_VALUE` = 0 or 1 gives a one-cycle pulse; 255 gives 255 cycles
- Not defined: type 8 behaves as reserved (output 0). No counter logic is synthesised.

## Test plan
- Reset: assert `RST` mid-stream with pin 0 on type 5 → all `GPIO_OUT` = 0 the same cycle. After release with no `CFG_UPDATE`, outputs stay 0 across 3 `UPDATE`s.
- PWM select: pin 1 type 5 value 200; drive `PWM_IN[200]` high at cycle N → `GPIO_OUT[1]`=1 at N+2. Value 249 → constant 0.
- Shadowing: `CFG_UPDATE` (pin 0 type 6 value 1) at cycle 10, `UPDATE` at cycle 40 → `GPIO_OUT[0]` is 0 until cycle 42, 1 from cycle 43.
- Simultaneous strobes: `CFG_UPDATE` and `UPDATE` both at cycle 20 with pin 2 type 2 → not applied until the next `UPDATE` at cycle 532.
- Toggle: pin 3 type 7; 4 `UPDATE`s → output sequence 1,0,1,0, each change 2 cycles after its `UPDATE`.
- Stretch (macro defined): type 8 value 5 → 5-cycle pulse per `UPDATE`. Retrigger after 3 cycles → high for 8 cycles total. Without the macro → constant 0.
